// File: rtl/tile_mem_arbiter.sv
// Tile-map RAM arbiter: fixed scanout read slot every tile, handshake writes in free cycles,
// and an optional full-map clear engine built when TILE_CLEAR_EN is defined.
module tile_mem_arbiter #(
   parameter int TILES_X    = 40,
   parameter int TILES_Y    = 30,
   parameter int TILE_SHIFT = 4,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 2
) (
   input  logic              VGA_clk,
   input  logic              rst_n,
   input  logic [9:0]        x_pos,
   input  logic [9:0]        y_pos,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] tile_q,
   output logic              frame_tick
);

   localparam int ACTIVE_W = TILES_X << TILE_SHIFT;
   localparam int ACTIVE_H = TILES_Y << TILE_SHIFT;
   localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(TILES_X * TILES_Y - 1);

   typedef enum logic [1:0] {WR_IDLE, WR_PEND, WR_ACK} wr_state_t;

   wr_state_t         wr_state, wr_state_nxt;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [ADDR_W-1:0] scan_addr;
   logic [ADDR_W-1:0] clr_cnt;
   logic              scan_slot;
   logic              scan_d;
   logic              wr_take;
   logic              wr_in_range;

   assign scan_slot = (x_pos[TILE_SHIFT-1:0] == '0) &&
                      (x_pos < 10'(ACTIVE_W)) && (y_pos < 10'(ACTIVE_H));
   assign scan_addr = ADDR_W'(32'(y_pos >> TILE_SHIFT) * 32'(TILES_X) +
                              32'(x_pos >> TILE_SHIFT));

   // A new write is not accepted while a clear sweep owns the map.
   assign wr_take     = (wr_state == WR_IDLE) && wr_req && !clr_busy;
   assign wr_in_range = (wr_addr_q <= LAST_TILE);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) wr_state <= WR_IDLE;
      else        wr_state <= wr_state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path through the
   // process leaves a signal unassigned and no latch is inferred.
   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_IDLE: if (wr_take)    wr_state_nxt = WR_PEND;
         WR_PEND: if (!scan_slot) wr_state_nxt = WR_ACK;
         WR_ACK:  if (!wr_req)    wr_state_nxt = WR_IDLE;
         default:                 wr_state_nxt = WR_IDLE;
      endcase
   end

   // Port mux: scan read beats a pending write, which beats a clear write.
   always_comb begin
      wr_ack    = (wr_state == WR_ACK);
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (scan_slot) begin
         mem_en   = 1'b1;
         mem_addr = scan_addr;
      end else if (wr_state == WR_PEND) begin
         mem_en    = wr_in_range;
         mem_we    = wr_in_range;
         mem_addr  = wr_addr_q;
         mem_wdata = wr_data_q;
      end else if (clr_busy) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = clr_cnt;
      end
   end

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         scan_d     <= 1'b0;
         tile_q     <= '0;
         frame_tick <= 1'b0;
      end else begin
         if (wr_take) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
         end
         // Read data returns the cycle after the slot; load it at the end of that cycle.
         scan_d <= scan_slot;
         if (scan_d) tile_q <= mem_rdata;
         frame_tick <= (x_pos == 10'd0) && (y_pos == 10'(ACTIVE_H));
      end
   end

`ifdef TILE_CLEAR_EN
   logic clr_hold;
   logic clr_start;
   logic clr_fire;

   // A request seen while a write is in flight is parked until the FSM is idle again.
   assign clr_start = !clr_busy && (wr_state == WR_IDLE) && (clr_req || clr_hold);
   assign clr_fire  = clr_busy && !scan_slot && (wr_state != WR_PEND);

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_busy <= 1'b0;
         clr_hold <= 1'b0;
         clr_cnt  <= '0;
      end else begin
         if (clr_start) begin
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
         end else if (clr_fire) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == LAST_TILE) clr_busy <= 1'b0;
         end
         clr_hold <= !clr_busy && (wr_state != WR_IDLE) && (clr_req || clr_hold);
      end
   end
`else
   logic clr_req_unused;

   assign clr_req_unused = clr_req;
   assign clr_busy       = 1'b0;
   assign clr_cnt        = '0;
`endif

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

- Shares the single-port snake tile-map RAM between two users: VGA scanout and game-logic writes.
- Scanout reads each 16×16 tile in a fixed slot, driven from the sync generator's `x_pos`/`y_pos`.
- Game logic writes through a four-phase request/acknowledge handshake in the remaining free cycles.
- An optional clear engine sweeps the whole map to zero.
- A start-of-vertical-blank tick schedules the game-state update.

## Interface

**Parameters**
- `TILES_X`, 40: tiles per row (640/16)
- `TILES_Y`, 30: tile rows (480/16)
- `TILE_SHIFT`, 4: log2 of tile size in pixels
- `ADDR_W`, 11: tile RAM address width
- `DATA_W`, 2: tile code width (0 empty, 1 snake, 2 food, 3 wall)

**Ports**
- `VGA_clk`, in, 1: pixel clock; the only clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `x_pos`, in, 10: horizontal counter from the sync generator
- `y_pos`, in, 10: vertical counter from the sync generator
- `wr_req`, in, 1: write request, level
- `wr_addr`, in, `ADDR_W`: write tile address; stable while `wr_req` is high
- `wr_data`, in, `DATA_W`: write tile code; stable while `wr_req` is high
- `wr_ack`, out, 1: write acknowledge
- `clr_req`, in, 1: start a full-map clear
- `clr_busy`, out, 1: clear sweep in progress
- `mem_en`, out, 1: RAM enable
- `mem_we`, out, 1: RAM write enable
- `mem_addr`, out, `ADDR_W`: RAM address
- `mem_wdata`, out, `DATA_W`: RAM write data
- `mem_rdata`, in, `DATA_W`: RAM read data; synchronous, valid the cycle after a read
- `tile_q`, out, `DATA_W`: registered tile code for the pixel colour logic
- `frame_tick`, out, 1: one-cycle pulse at the start of vertical blank

## Operation

**Scan slot**
- Occurs when `x_pos[3:0]==0 && x_pos<640 && y_pos<480`.
- Drives `mem_en=1`, `mem_we=0`, `mem_addr=(y_pos>>4)*TILES_X+(x_pos>>4)`.
- The scan slot always wins arbitration.

**Free cycle**
- Any cycle that is not a scan slot.
- Slot priority: scan slot, then pending write, then clear.

**Write FSM**
- `IDLE`: on `wr_req=1` and no clear sweep active, capture `wr_addr`/`wr_data`, go to `PEND`.
- `PEND`: on the first free cycle, drive a RAM write (`mem_en=1`, `mem_we=1`), go to `ACK`.
- `ACK`: hold `wr_ack=1` until `wr_req=0`, then go to `IDLE`.
- Captured address ≥ `TILES_X*TILES_Y` (1200): the write is suppressed (`mem_en=0` in that cycle), but the FSM still goes to `ACK`.
- A request arriving during a clear sweep stays pending in `IDLE` until `clr_busy` falls.

**Clear engine**
- A `clr_req` seen while `clr_busy=0` and the write FSM is in `IDLE` sets `clr_busy` and zeroes the clear counter.
- Each free cycle not used by a write writes 0 to the counter address, then increments the counter.
- After writing address 1199, `clr_busy` falls on the next edge.
- `clr_req` is ignored while `clr_busy=1`.
- A `clr_req` arriving while the write FSM is in `PEND` or `ACK` is held and starts the sweep when the FSM returns to `IDLE`.

**Idle RAM port**
- In any cycle with no scan slot, write or clear write: `mem_en=0`, `mem_we=0`.

**Frame tick**
- `frame_tick` is registered high for the single cycle after `x_pos==0 && y_pos==480` is sampled.

## Timing

- RAM outputs are combinational from the registered state and `x_pos`/`y_pos`.
- The RAM samples them at the end of the same cycle.
- Scan-read latency: `tile_q` loads `mem_rdata` at the edge ending the cycle after the slot, so it is valid from `x_pos=16k+2`. It holds until the next slot's load.
- Pixel colour logic delays `display_enable` by one extra cycle to stay aligned with `tile_q`.
- Write latency: `PEND` to RAM write is 1 cycle when the next cycle is free, 2 cycles when it lands on a scan slot.
- `wr_ack` rises the cycle after the RAM write.
- Full clear: 1200 writes over free cycles.
  - During blanking: about 1200 cycles.
  - During active video: at most 16/15 of that.
- Reset values, applied asynchronously on `rst_n=0`:
  - outputs: `wr_ack=0`, `clr_busy=0`, `tile_q=0`, `frame_tick=0`
  - state: FSM `IDLE`, clear counter 0
  - any in-flight write or sweep is abandoned; no acknowledge is issued

## Configuration

- Macro `TILE_CLEAR_EN`.
- Defined: the clear engine is built as described above.
- Undefined:
  - the clear engine is not built
  - `clr_req` is ignored
  - `clr_busy` is tied to 0
  - every free cycle is available to the write FSM

## Test plan

1. **Scan slot:** `x_pos=32`, `y_pos=48` → that cycle `mem_en=1`, `mem_we=0`, `mem_addr=122`; with `mem_rdata=2` in the next cycle, `tile_q=2` from `x_pos=34` onward.
2. **Write, free slot:** `wr_req` with `addr=5`, `data=3` at `x_pos=700` → one RAM write `addr=5`, `wdata=3`; `wr_ack` high the following cycle; drop `wr_req` → `wr_ack` low next cycle.
3. **Write collides with scan slot:** `PEND` coincides with `x_pos=16`, `y_pos=0` → scan read goes first, write lands on `x_pos=17`, ack one cycle later.
4. **Out-of-range write:** `wr_addr=1500` → `mem_en` stays 0, `wr_ack` still asserts.
5. **Clear (with `TILE_CLEAR_EN`):** `clr_req` during vertical blank → 1200 consecutive writes of 0 to addresses 0..1199, then `clr_busy` falls; a `wr_req` raised mid-sweep is acknowledged only after that.
6. **Frame tick and reset:** `frame_tick` is high for exactly 1 cycle per frame, after `x_pos=0`, `y_pos=480`; assert `rst_n=0` mid-`PEND` → `wr_ack=0`, `clr_busy=0`, `tile_q=0` immediately, and no RAM write occurs.
